muldiv_unit: RTL

//   Multi-cycle multiply/divide engine with the architectural HI/LO registers.
//   ALU_OPT_MULT and the divide ops are issued here, not to the single-cycle ALU.

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit_div_core.sv | 22 ++
 rtl/muldiv_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode codes, FSM states and sizing constants for the multiply/divide engine.
// Decode and execute stages import the same definitions.
package muldiv_unit_pkg;

    localparam int unsigned MD_OPT_WIDTH = 3;
    localparam int unsigned ITER_STEPS   = 32;
    localparam int unsigned CNT_W        = 5;

    typedef enum logic [MD_OPT_WIDTH-1:0] {
        MdOptMult  = 3'd0,
        MdOptMultu = 3'd1,
        MdOptDiv   = 3'd2,
        MdOptDivu  = 3'd3,
        MdOptMthi  = 3'd4,
        MdOptMtlo  = 3'd5
    } md_opt_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } md_state_e;

    function automatic logic opt_legal(input logic [MD_OPT_WIDTH-1:0] opt);
        return opt <= 3'd5;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor if it fits, and shift the resulting quotient bit in.
module muldiv_unit_div_core (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);

    logic [32:0] shifted;
    logic        fits;

    always_comb begin
        shifted  = {rem, quo[31]};
        fits     = shifted >= {1'b0, divisor};
        // When it fits the difference is below the divisor, so bit 32 is always zero.
        rem_next = fits ? (shifted[31:0] - divisor) : shifted[31:0];
        quo_next = {quo[30:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine holding the architectural HI/LO registers.
// Optional MULDIV_FAST_MULT_EN turns MULT/MULTU into a single-cycle multiply.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MD_OPT_WIDTH-1:0] opt,
    input  logic [31:0]             opr1,
    input  logic [31:0]             opr2,
    input  logic                    cancel,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             hi,
    output logic [31:0]             lo,
    output logic                    illegal_opt
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Shared shift register: {partial product} for multiply, {remainder, quotient} for divide.
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opb_q, opb_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             done_q, done_d;

    logic        accept;
    logic        is_signed;
    logic        sign1, sign2;
    logic [31:0] mag1, mag2;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [31:0] div_rem_next, div_quo_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign illegal_opt = start & ~busy & ~opt_legal(opt);

    muldiv_unit_div_core u_div_core (
        .rem      (acc_q[63:32]),
        .quo      (acc_q[31:0]),
        .divisor  (opb_q),
        .rem_next (div_rem_next),
        .quo_next (div_quo_next)
    );

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fast_prod;
    always_comb begin
        fast_prod = {{32{sign1}}, opr1} * {{32{sign2}}, opr2};
    end
`endif

    always_comb begin
        accept    = start & ~busy & ~cancel & opt_legal(opt);
        is_signed = (opt == MdOptMult) || (opt == MdOptDiv);
        sign1     = is_signed & opr1[31];
        sign2     = is_signed & opr2[31];
        mag1      = sign1 ? -opr1 : opr1;
        mag2      = sign2 ? -opr2 : opr2;

        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
        mul_next  = {mul_sum, acc_q[31:1]};

        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
        rem_fix   = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (opt)
                        MdOptMult, MdOptMultu: begin
`ifdef MULDIV_FAST_MULT_EN
                            {hi_d, lo_d} = fast_prod;
                            done_d       = 1'b1;
`else
                            state_d   = StRun;
                            cnt_d     = CNT_W'(ITER_STEPS - 1);
                            acc_d     = {32'd0, mag2};
                            opb_d     = mag1;
                            is_div_d  = 1'b0;
                            neg_res_d = sign1 ^ sign2;
                            neg_rem_d = 1'b0;
`endif
                        end
                        MdOptDiv, MdOptDivu: begin
                            if (opr2 == 32'd0) begin
                                lo_d   = 32'hFFFF_FFFF;
                                hi_d   = opr1;
                                done_d = 1'b1;
                            end else begin
                                state_d   = StRun;
                                cnt_d     = CNT_W'(ITER_STEPS - 1);
                                acc_d     = {32'd0, mag1};
                                opb_d     = mag2;
                                is_div_d  = 1'b1;
                                neg_res_d = sign1 ^ sign2;
                                neg_rem_d = sign1;
                            end
                        end
                        MdOptMthi: begin
                            hi_d   = opr1;
                            done_d = 1'b1;
                        end
                        MdOptMtlo: begin
                            lo_d   = opr1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    acc_d = is_div_q ? {div_rem_next, div_quo_next} : mul_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                // A flush in the fix cycle discards the result entirely.
                if (!cancel) begin
                    if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule
